// File: rtl/mdu_if.sv
// Operand, control and result bundle between the E stage and the multiply/divide unit.
interface mdu_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output start, op, SrcA, SrcB, input busy, HI, LO);
    modport slave  (input start, op, SrcA, SrcB, output busy, HI, LO);
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO; results are computed at launch
// and committed to HI/LO once the fixed busy period expires.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES);

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, mag_q, mag_r;
    logic [31:0] sdiv_q, sdiv_r, udiv_q, udiv_r;
    logic        b_zero;

    // Signed divide works on magnitudes so the most-negative / -1 case wraps cleanly.
    always_comb begin
        prod_s = {{32{bus.SrcA[31]}}, bus.SrcA} * {{32{bus.SrcB[31]}}, bus.SrcB};
        prod_u = {32'b0, bus.SrcA} * {32'b0, bus.SrcB};
        b_zero = (bus.SrcB == 32'b0);
        abs_a  = bus.SrcA[31] ? (32'b0 - bus.SrcA) : bus.SrcA;
        abs_b  = bus.SrcB[31] ? (32'b0 - bus.SrcB) : bus.SrcB;
        mag_q  = b_zero ? 32'b0 : abs_a / abs_b;
        mag_r  = b_zero ? 32'b0 : abs_a % abs_b;
        sdiv_q = (bus.SrcA[31] ^ bus.SrcB[31]) ? (32'b0 - mag_q) : mag_q;
        sdiv_r = bus.SrcA[31] ? (32'b0 - mag_r) : mag_r;
        udiv_q = b_zero ? 32'b0 : bus.SrcA / bus.SrcB;
        udiv_r = b_zero ? 32'b0 : bus.SrcA % bus.SrcB;
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        3'd1: begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                            pend_wr_d = 1'b1;
                            count_d   = MULT_LOAD;
                            state_d   = BUSY;
                        end
                        3'd2: begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                            pend_wr_d = 1'b1;
                            count_d   = MULT_LOAD;
                            state_d   = BUSY;
                        end
                        3'd3: begin
                            pend_hi_d = sdiv_r;
                            pend_lo_d = sdiv_q;
                            pend_wr_d = !b_zero;
                            count_d   = DIV_LOAD;
                            state_d   = BUSY;
                        end
                        3'd4: begin
                            pend_hi_d = udiv_r;
                            pend_lo_d = udiv_q;
                            pend_wr_d = !b_zero;
                            count_d   = DIV_LOAD;
                            state_d   = BUSY;
                        end
                        3'd5:    hi_d = bus.SrcA;
                        3'd6:    lo_d = bus.SrcA;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                // A divide by zero still runs the full period but never commits.
                if (count_q == 5'd1) begin
                    state_d = IDLE;
                    count_d = 5'd0;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    count_d = count_q - 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= 5'd0;
            pend_hi_q <= 32'b0;
            pend_lo_q <= 32'b0;
            pend_wr_q <= 1'b0;
            hi_q      <= 32'b0;
            lo_q      <= 32'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy = (state_q == BUSY);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit that sits in the E stage beside the ALU.
- Consumes the forwarded E-stage operands (E_MFRS, E_MFRT) and owns the HI/LO registers.
- Multi-cycle: asserts busy for a fixed latency. The hazard logic stalls D (holds F/D, clears E) while `start || busy` and a D-stage instruction uses the MDU.
- mfhi/mflo read HI/LO combinationally in E and feed the E/M result path.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal 1–31).
- DIV_CYCLES, 10, busy cycles for div/divu (legal 1–31).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately.
- start  input  1  one-cycle request to launch the operation in `op`; sampled on the rising clk edge.
- op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op).
- SrcA  input  32  rs operand (forwarded).
- SrcB  input  32  rt operand (forwarded).
- busy  output  1  high while a mult/div is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset (reset==0, async): state=IDLE, counter=0, busy=0, HI=0, LO=0. Any in-flight result is discarded. Outputs stay at these values until reset deasserts.
- States: IDLE, BUSY. Counter width is 5 bits.
- IDLE, start=1, op in {1..4}:
  - Compute the result from SrcA/SrcB at this edge and hold it in pending_hi/pending_lo.
  - Load counter = MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY; busy=1 from the next cycle.
- IDLE, start=1, op=5: HI<=SrcA at this edge; op=6: LO<=SrcA at this edge. busy stays 0, no state change.
- IDLE, start=1, op in {0,7}, or start=0: no effect.
- BUSY: counter decrements each edge. On the edge where counter==1:
  - HI<=pending_hi, LO<=pending_lo, busy<=0, state<=IDLE.
- Latency: start sampled at edge T → busy high for exactly N cycles (edges T+1 .. T+N). HI/LO show the new value after edge T+N, in the same cycle busy is first low again.
- HI/LO hold their old values throughout BUSY.
- start while BUSY (any op, including mthi/mtlo): ignored, no error. The hazard unit guarantees this never happens legally.
- Arithmetic:
  - mult: signed 32×32→64, {HI,LO} = product.
  - multu: unsigned 32×32→64, {HI,LO} = product.
  - div (signed): LO = quotient truncated toward zero; HI = remainder carrying the sign of the dividend (SrcA).
  - divu: unsigned quotient/remainder.
- Divide by zero (div/divu, SrcB==0): full DIV_CYCLES busy period still occurs; HI/LO are left unchanged.
- Overflow, div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- A start sampled on the same edge busy falls cannot occur (busy is high in that cycle, so start is ignored). Back-to-back ops therefore have a minimum of N+1 cycles between starts.
- Reset asserted mid-BUSY: abort immediately. On release, IDLE with HI=LO=0.
- busy and HI/LO are registered outputs. There are no combinational paths from the inputs to the outputs.

Test Plan:
- Reset then release, start=1, op=1 (mult), SrcA=0xFFFFFFFE (−2), SrcB=3 → busy=1 for exactly 5 cycles; the following cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy=0.
- op=2 (multu), SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF → after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
- op=3 (div), SrcA=0xFFFFFFF9 (−7), SrcB=2 → 10 busy cycles, then LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- op=4 (divu), SrcA=7, SrcB=0, with HI=0x11, LO=0x22 preloaded via mthi/mtlo → mthi/mtlo give busy=0 and HI/LO updated the next cycle; divu gives busy for 10 cycles; HI=0x11, LO=0x22 unchanged.
- During a mult busy period, pulse start with op=6, SrcA=0xDEAD → LO ends with the mult result, not 0xDEAD; busy duration unchanged.
- Start op=3 (div), drop reset to 0 at busy cycle 4, release → busy=0, HI=LO=0 immediately and after release; no late write-back occurs.
